// File: rtl/iob_clint_tick_pkg.sv
// Shared types and sizing helpers for the CLINT tick generator.
package iob_clint_tick_pkg;

  localparam int unsigned DEF_FREQ_HZ     = 100_000_000;
  localparam int unsigned DEF_TICK_HZ     = 100_000;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_RTC_TIMEOUT = 8192;
  localparam int unsigned DEF_ACQ_EDGES   = 2;

  // Register width for holding values 0..n-1, never narrower than one bit.
  function automatic int unsigned min_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned calc_div(input int unsigned freq_hz, input int unsigned tick_hz);
    return freq_hz / tick_hz;
  endfunction

  // Sizing for the default configuration; instances derive their own from parameters.
  localparam int unsigned DIV   = calc_div(DEF_FREQ_HZ, DEF_TICK_HZ);
  localparam int unsigned DIV_W = min_width(DIV);
  localparam int unsigned WD_W  = min_width(DEF_RTC_TIMEOUT + 1);
  localparam int unsigned ACQ_W = min_width(DEF_ACQ_EDGES + 1);

  typedef enum logic [1:0] {
    ST_INT  = 2'd0,
    ST_ACQ  = 2'd1,
    ST_RUN  = 2'd2,
    ST_LOST = 2'd3
  } tick_state_e;

endpackage

// File: rtl/iob_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input followed by a registered
// rising-edge detector. Free-running: never gated by a clock enable.
module iob_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic arst_n_i,
  input  logic d_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/iob_clint_tick_gen.sv
// CLINT mtime increment generator: internal divider or external RTC, with an
// RTC liveness watchdog that falls back to the divider when edges stop.
module iob_clint_tick_gen
  import iob_clint_tick_pkg::*;
#(
  parameter int unsigned FREQ_HZ     = DEF_FREQ_HZ,
  parameter int unsigned TICK_HZ     = DEF_TICK_HZ,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned RTC_TIMEOUT = DEF_RTC_TIMEOUT,
  parameter int unsigned ACQ_EDGES   = DEF_ACQ_EDGES
) (
  input  logic clk_i,
  input  logic arst_n_i,
  input  logic cke_i,
  input  logic rtc_i,
  input  logic rtc_en_i,
  output logic tick_o,
  output logic rtc_active_o,
  output logic rtc_lost_o
);

  localparam int unsigned CNT_DIV = calc_div(FREQ_HZ, TICK_HZ);
  localparam int unsigned CNT_W   = min_width(CNT_DIV);
  localparam int unsigned WDOG_W  = min_width(RTC_TIMEOUT + 1);
  localparam int unsigned EDGE_W  = min_width(ACQ_EDGES + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CNT_DIV - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(RTC_TIMEOUT - 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(RTC_TIMEOUT);
  localparam logic [EDGE_W-1:0] EDGE_LOCK = EDGE_W'(ACQ_EDGES);

  tick_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WDOG_W-1:0] wd_q, wd_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic              tick_q, tick_d;
  logic              active_q, active_d;
  logic              lost_q, lost_d;

  logic rtc_rise;
  logic div_hit;
  logic timeout;
  logic state_chg;

  iob_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk_i   (clk_i),
    .arst_n_i(arst_n_i),
    .d_i     (rtc_i),
    .rise_o  (rtc_rise)
  );

  // Next-state, divider, watchdog and output logic.
  always_comb begin
    state_d  = state_q;
    edge_d   = edge_q;
    lost_d   = lost_q;
    div_hit  = (cnt_q == CNT_LAST);
    timeout  = (wd_q == WDOG_LAST) && !rtc_rise;

    case (state_q)
      ST_INT: begin
        if (rtc_en_i) state_d = ST_ACQ;
      end
      ST_ACQ: begin
        if (rtc_rise) begin
          if (edge_q + EDGE_W'(1) == EDGE_LOCK) state_d = ST_RUN;
          else                                  edge_d  = edge_q + EDGE_W'(1);
        end else if (timeout) begin
          edge_d = '0;
        end
      end
      ST_RUN: begin
        if (timeout) begin
          state_d = ST_LOST;
          lost_d  = 1'b1;
        end
      end
      ST_LOST: begin
        state_d = ST_LOST;
      end
      default: state_d = ST_INT;
    endcase

    // Dropping the request overrides every other transition.
    if (!rtc_en_i) begin
      state_d = ST_INT;
      lost_d  = 1'b0;
    end

    if (state_d != ST_ACQ) edge_d = '0;
    state_chg = (state_d != state_q);

    // Divider restarts a full period whenever it becomes the tick source again.
    cnt_d = div_hit ? '0 : cnt_q + CNT_W'(1);
    if (state_chg && (state_d != ST_RUN)) cnt_d = '0;

    wd_d = (wd_q == WDOG_MAX) ? wd_q : wd_q + WDOG_W'(1);
    if (rtc_rise || state_chg) wd_d = '0;

    // The locking edge is seen in ACQ, so it never produces an extra tick.
    tick_d   = (state_q == ST_RUN) ? rtc_rise : div_hit;
    active_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q  <= ST_INT;
      cnt_q    <= '0;
      wd_q     <= '0;
      edge_q   <= '0;
      tick_q   <= 1'b0;
      active_q <= 1'b0;
      lost_q   <= 1'b0;
    end else if (cke_i) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wd_q     <= wd_d;
      edge_q   <= edge_d;
      tick_q   <= tick_d;
      active_q <= active_d;
      lost_q   <= lost_d;
    end
  end

  assign tick_o       = tick_q;
  assign rtc_active_o = active_q;
  assign rtc_lost_o   = lost_q;

endmodule
